conv1_frame_ctrl: RTL and testbench

- Frame sequencer for the conv1 layer; one instance per conv1 instance.
- On a start pulse it reads one IMG_IN_WIDTH x IMG_IN_WIDTH 8-bit frame from a pixel RAM in raster order and streams it into conv1 as cnn_data_in / cnn_data_in_valid / img_in_en.
- It counts conv1 output strobes and signals done after (IMG_IN_WIDTH-KERNEL_WIDTH+1)^2 results, or flags a timeout.
- Sits between the pixel RAM and conv1 and is the only driver of conv1's input handshake.

---
 rtl/conv1_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_conv1_frame_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1_frame_ctrl.sv
`timescale 1ns/1ps
// conv1_frame_ctrl
// Frame sequencer for one conv1 instance. A start pulse in IDLE launches a
// raster-order read of an IMG_IN_WIDTH x IMG_IN_WIDTH pixel frame from the
// pixel RAM. The pixels are streamed into conv1 while the controller counts
// conv1 output strobes. It finishes with a one-cycle done pulse, or it raises
// err_timeout if the results stop arriving.
//
// Optional build macro CONV1_FRAME_CTRL_PERF_EN adds the perf_cycles and
// perf_stall counters.
//
// Ports
//   clk               clock, rising edge
//   rst_n             synchronous reset, active-high (1 = reset)
//   start             one-cycle frame request, honoured only in IDLE
//   stall             holds pixel issue while high
//   pix_rd_en/addr    pixel RAM read strobe and address
//   pix_rd_data       RAM data, one cycle after pix_rd_en
//   cnn_data_in       pixel to conv1
//   cnn_data_in_valid pixel valid to conv1
//   img_in_en         frame-active enable to conv1
//   conv_out_valid    conv1 result strobe
//   busy              high outside IDLE
//   done              one-cycle completion pulse
//   err_timeout       sticky drain timeout flag
//   out_cnt           conv1 results counted this frame
//   perf_cycles       (PERF_EN) start-to-done cycles, inclusive
//   perf_stall        (PERF_EN) FETCH cycles spent stalled
module conv1_frame_ctrl #(
  parameter int IMG_IN_WIDTH  = 27,
  parameter int KERNEL_WIDTH  = 5,
  parameter int ADDR_W        = 10,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [7:0]        pix_rd_data,
  output logic [7:0]        cnn_data_in,
  output logic              cnn_data_in_valid,
  output logic              img_in_en,
  input  logic              conv_out_valid,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] out_cnt
`ifdef CONV1_FRAME_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stall
`endif
);

  localparam int NPIX    = IMG_IN_WIDTH * IMG_IN_WIDTH;
  localparam int NOUT    = (IMG_IN_WIDTH - KERNEL_WIDTH + 1) * (IMG_IN_WIDTH - KERNEL_WIDTH + 1);
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0]  NOUT_C     = ADDR_W'(NOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic                vld_p1_q;
  logic                img_en_q;
  logic                err_q;
  logic                rd_issue, last_issue, cnt_full, drain_expire;

  // Result counter stops at NOUT so late strobes cannot overrun it.
  function automatic logic [ADDR_W-1:0] sat_cnt_inc(input logic [ADDR_W-1:0] v);
    return (v == NOUT_C) ? v : v + 1'b1;
  endfunction

  // Stage p0: issue decision. Stall acts in the same cycle, so the read
  // strobe is decoded from state rather than registered ahead of time.
  assign rd_issue     = (state_q == S_FETCH) && !stall;
  assign last_issue   = rd_issue && (rd_ptr_q == LAST_ADDR);
  assign drain_expire = (drain_cnt_q == DRAIN_LAST);

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (state_q != S_IDLE && conv_out_valid)
      out_cnt_d = sat_cnt_inc(out_cnt_q);
  end

  // Include this cycle's strobe so completion is seen without an extra cycle.
  assign cnt_full = (out_cnt_d == NOUT_C);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      vld_p1_q    <= 1'b0;
      img_en_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      vld_p1_q  <= rd_issue;
      out_cnt_q <= out_cnt_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
          end
        end
        S_FETCH: begin
          if (rd_issue) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            // Rises together with the first pixel valid.
            img_en_q <= 1'b1;
          end
          if (last_issue) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 1'b1;
          // Completion is tested first so it wins over a simultaneous timeout.
          if (cnt_full) begin
            state_q  <= S_DONE;
            img_en_q <= 1'b0;
          end else if (drain_expire) begin
            state_q  <= S_DONE;
            img_en_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stage p1: the RAM output register already delays data by one cycle, so
  // the valid register is the stage that aligns with it. Data is masked
  // while invalid so that idle or reset cycles present zero to conv1.
  assign cnn_data_in_valid = vld_p1_q;
  assign cnn_data_in       = vld_p1_q ? pix_rd_data : 8'd0;

  assign pix_rd_en   = rd_issue;
  assign pix_rd_addr = rd_ptr_q;
  assign img_in_en   = img_en_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_timeout = err_q;
  assign out_cnt     = out_cnt_q;

`ifdef CONV1_FRAME_CTRL_PERF_EN
  logic [31:0] perf_cyc_q;
  logic [15:0] perf_stl_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The acceptance cycle itself counts as 1; every busy cycle through DONE adds one.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cyc_q <= 32'd1;
      perf_stl_q <= '0;
    end else if (state_q != S_IDLE) begin
      perf_cyc_q <= sat_inc32(perf_cyc_q);
      if (state_q == S_FETCH && stall)
        perf_stl_q <= sat_inc16(perf_stl_q);
    end
  end

  assign perf_cycles = perf_cyc_q;
  assign perf_stall  = perf_stl_q;
`endif

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
`timescale 1ns/1ps
// Directed scoreboard bench for conv1_frame_ctrl. The bench models the pixel
// RAM (data = addr[7:0], one-cycle read latency) and a conv1 stand-in. The
// stand-in strobes once for every pixel at row >= 4 and column >= 4, with a
// configurable strobe limit.
module tb_conv1_frame_ctrl;
  localparam int W    = 27;
  localparam int K    = 5;
  localparam int AW   = 10;
  localparam int TO   = 64;
  localparam int NPIX = W * W;
  localparam int NOUT = (W - K + 1) * (W - K + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, stall;
  logic          pix_rd_en, cnn_data_in_valid, img_in_en, conv_out_valid;
  logic          busy, done, err_timeout;
  logic [AW-1:0] pix_rd_addr, out_cnt;
  logic [7:0]    pix_rd_data, cnn_data_in;
`ifdef CONV1_FRAME_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_stall;
`endif

  always #5 clk = ~clk;

  conv1_frame_ctrl #(.IMG_IN_WIDTH(W), .KERNEL_WIDTH(K), .ADDR_W(AW), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .cnn_data_in(cnn_data_in), .cnn_data_in_valid(cnn_data_in_valid), .img_in_en(img_in_en),
    .conv_out_valid(conv_out_valid), .busy(busy), .done(done),
    .err_timeout(err_timeout), .out_cnt(out_cnt)
`ifdef CONV1_FRAME_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  typedef struct { int c_at; logic [7:0] d; } sb_t;
  sb_t sb[$];

  int   n_chk = 0, n_pass = 0, cycle = 0;
  logic start_nx = 1'b0, stall_nx = 1'b0, rst_nx = 1'b1, stall_cur = 1'b0;
  logic [7:0] nxt_rd_data = 8'hA5;
  logic nxt_cov = 1'b0;
  int   exp_addr, px_idx, sent, strobe_lim, n_reads, done_cnt;
  int   first_rd, last_rd, first_vld, last_vld;
  int   exp_perf_cyc = 0, exp_perf_stl = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: inputs change just after the rising edge, and outputs
  // are sampled and fed to the models on the falling edge.
  task automatic tick();
    sb_t e;
    @(posedge clk); #1;
    rst_n = rst_nx; start = start_nx; stall = stall_nx; stall_cur = stall_nx;
    pix_rd_data = nxt_rd_data; conv_out_valid = nxt_cov;
    @(negedge clk);
    cycle++;
    nxt_rd_data = 8'hA5;
    nxt_cov = 1'b0;
    if (stall_cur) chk("stall_blocks_read", pix_rd_en, 0);
    if (pix_rd_en === 1'b1) begin
      chk("rd_addr", pix_rd_addr, exp_addr);
      sb.push_back('{c_at: cycle, d: 8'(exp_addr)});
      nxt_rd_data = pix_rd_addr[7:0];
      exp_addr++;
      n_reads++;
      if (first_rd < 0) first_rd = cycle;
      last_rd = cycle;
    end
    if (cnn_data_in_valid === 1'b1) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pix_latency", cycle - e.c_at, 1);
        chk("pix_data", cnn_data_in, e.d);
      end
      if ((px_idx / W) >= K - 1 && (px_idx % W) >= K - 1 && sent < strobe_lim) begin
        nxt_cov = 1'b1;
        sent++;
      end
      px_idx++;
      if (first_vld < 0) first_vld = cycle;
      last_vld = cycle;
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ":busy"}, busy, 0);
    chk({nm, ":done"}, done, 0);
    chk({nm, ":err_timeout"}, err_timeout, 0);
    chk({nm, ":pix_rd_en"}, pix_rd_en, 0);
    chk({nm, ":pix_rd_addr"}, pix_rd_addr, 0);
    chk({nm, ":cnn_data_in"}, cnn_data_in, 0);
    chk({nm, ":cnn_valid"}, cnn_data_in_valid, 0);
    chk({nm, ":img_in_en"}, img_in_en, 0);
    chk({nm, ":out_cnt"}, out_cnt, 0);
`ifdef CONV1_FRAME_CTRL_PERF_EN
    chk({nm, ":perf_cycles"}, perf_cycles, 0);
    chk({nm, ":perf_stall"}, perf_stall, 0);
`endif
  endtask

  // Runs one frame from the start pulse to done (or to an abort reset).
  task automatic run_frame(input string nm, input int lim, input int stall_at, input int stall_len,
                           input int spur_at, input int abort_at, input int exp_done, input bit exp_err);
    int t0, rel, stalled, done_rel;
    bit spur_done, aborted;
    exp_addr = 0; px_idx = 0; sent = 0; strobe_lim = lim; n_reads = 0; done_cnt = 0;
    first_rd = -1; last_rd = -1; first_vld = -1; last_vld = -1;
    sb.delete();
    stalled = 0; spur_done = 0; aborted = 0; done_rel = -1;
    start_nx = 1'b1;
    tick();
    start_nx = 1'b0;
    t0 = cycle;
    chk({nm, ":busy_at_start"}, busy, 0);
    chk({nm, ":done_at_start"}, done, 0);
`ifdef CONV1_FRAME_CTRL_PERF_EN
    chk({nm, ":perf_cycles_prev"}, perf_cycles, exp_perf_cyc);
    chk({nm, ":perf_stall_prev"}, perf_stall, exp_perf_stl);
`endif
    for (int i = 0; i < 3000; i++) begin
      stall_nx = (stall_len > 0 && exp_addr == stall_at && stalled < stall_len);
      start_nx = (spur_at >= 0 && exp_addr == spur_at && !spur_done);
      if (start_nx) spur_done = 1;
      rst_nx = (abort_at >= 0 && exp_addr == abort_at);
      tick();
      if (stall_cur) stalled++;
      rel = cycle - t0;
      if (rel == 1) begin
        chk({nm, ":busy_c1"}, busy, 1);
        chk({nm, ":err_cleared_c1"}, err_timeout, 0);
        chk({nm, ":out_cnt_cleared_c1"}, out_cnt, 0);
        chk({nm, ":img_en_c1"}, img_in_en, 0);
      end
      if (rel == 2) chk({nm, ":img_en_c2"}, img_in_en, 1);
      if (exp_done > 0 && rel == exp_done - 1) chk({nm, ":err_before_done"}, err_timeout, 0);
      if (rst_nx) begin aborted = 1; break; end
      if (done === 1'b1) begin done_rel = rel; break; end
    end
    start_nx = 1'b0; stall_nx = 1'b0;
    if (aborted) begin
      rst_nx = 1'b0;
      tick();
      check_zero({nm, ":after_abort"});
      sb.delete();
      done_cnt = 0;
      for (int i = 0; i < 800; i++) tick();
      chk({nm, ":no_done_after_abort"}, done_cnt, 0);
      chk({nm, ":idle_after_abort"}, busy, 0);
      exp_perf_cyc = 0; exp_perf_stl = 0;
    end else begin
      chk({nm, ":done_seen"}, done_rel >= 0, 1);
      chk({nm, ":done_cycle"}, done_rel, exp_done);
      chk({nm, ":done_once"}, done_cnt, 1);
      chk({nm, ":out_cnt"}, out_cnt, lim);
      chk({nm, ":err_timeout"}, err_timeout, exp_err);
      chk({nm, ":img_en_at_done"}, img_in_en, 0);
      chk({nm, ":reads"}, n_reads, NPIX);
      chk({nm, ":first_rd"}, first_rd - t0, 1);
      chk({nm, ":last_rd"}, last_rd - t0, NPIX + stall_len);
      chk({nm, ":first_vld"}, first_vld - t0, 2);
      chk({nm, ":last_vld"}, last_vld - t0, NPIX + 1 + stall_len);
      chk({nm, ":sb_drained"}, sb.size(), 0);
      exp_perf_cyc = done_rel + 1; exp_perf_stl = stall_len;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; pix_rd_data = 8'hA5; conv_out_valid = 1'b0;
    rst_nx = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst_nx = 1'b0;
    tick();
    check_zero("idle");

    // Nominal frame: done lands one cycle after the last strobe (cycle 731).
    run_frame("nominal", NOUT, -1, 0, -1, -1, 732, 0);
    // Back-to-back start in the first IDLE cycle, with 10 stall cycles at rd_ptr=100.
    run_frame("stall", NOUT, 100, 10, -1, -1, 742, 0);
    // Starved conv1: DRAIN begins at cycle 730, so the timeout lands 64 cycles later.
    run_frame("timeout", 500, -1, 0, -1, -1, 730 + TO, 1);
    repeat (3) tick();
    chk("err_sticky_idle", err_timeout, 1);
    chk("out_cnt_hold_idle", out_cnt, 500);
    // A start during FETCH is ignored; the frame also clears the sticky error.
    run_frame("spur_start", NOUT, -1, 0, 300, -1, 732, 0);
    // Reset at rd_ptr=300 aborts the frame.
    run_frame("abort", NOUT, -1, 0, -1, 300, 0, 0);
    // Recovery after the abort.
    run_frame("recover", NOUT, -1, 0, -1, -1, 732, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
